// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      mem_valid;
    logic                      mem_ready;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_rsp_valid;
    logic [DATA_W-1:0]         mem_rdata;

    // Arbiter side: serves requesters, drives the memory command port.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  mem_ready, mem_rsp_valid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_valid, mem_write, mem_addr, mem_wdata
    );

    // Environment side: requesters plus the downstream memory.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output mem_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_valid, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port, one transaction in flight
module mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 4096
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, ERR_RSP} state_t;

    state_t              state, state_nx;
    logic [IDX_W-1:0]    last_grant, grant_idx, cur_idx;
    logic                grant_found, grant_fire, addr_mapped, rsp_pending;
    logic [ADDR_W-1:0]   sel_addr;
    logic                cur_write;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [NUM_REQ-1:0]  cur_onehot;
    logic [NUM_REQ-1:0]  rsp_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                rsp_err_r;
    int                  cand;

    assign sel_addr    = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign addr_mapped = (64'(sel_addr) < 64'(MEM_DEPTH));
    assign cur_onehot  = NUM_REQ'(1) << cur_idx;
    // A response pulse still on the wire holds off the next grant by one cycle.
    assign rsp_pending = |rsp_valid_r;

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.mem_write = cur_write;
    assign bus.mem_addr  = cur_addr;
    assign bus.mem_wdata = cur_wdata;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic plus the combinational handshake outputs.
    always_comb begin
        state_nx      = state;
        grant_fire    = 1'b0;
        bus.req_ready = '0;
        bus.mem_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && !rsp_pending) begin
                    grant_fire               = 1'b1;
                    bus.req_ready[grant_idx] = 1'b1;
                    state_nx                 = addr_mapped ? ISSUE : ERR_RSP;
                end
            end
            ISSUE: begin
                bus.mem_valid = 1'b1;
                if (bus.mem_ready) state_nx = cur_write ? IDLE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (bus.mem_rsp_valid) state_nx = IDLE;
            end
            ERR_RSP:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        // Keep handshakes quiet for the whole reset window, including its first cycle.
        if (rst) begin
            grant_fire    = 1'b0;
            bus.req_ready = '0;
            bus.mem_valid = 1'b0;
        end
    end

    // Grant latching and one-cycle response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= IDX_W'(NUM_REQ - 1);
            cur_idx     <= '0;
            cur_write   <= 1'b0;
            cur_addr    <= '0;
            cur_wdata   <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            if (grant_fire) begin
                last_grant <= grant_idx;
                cur_idx    <= grant_idx;
                cur_write  <= bus.req_write[grant_idx];
                cur_addr   <= sel_addr;
                cur_wdata  <= bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            end
            case (state)
                ISSUE: begin
                    if (bus.mem_ready && cur_write) rsp_valid_r <= cur_onehot;
                end
                WAIT_RSP: begin
                    if (bus.mem_rsp_valid) begin
                        rsp_valid_r <= cur_onehot;
                        rsp_rdata_r <= bus.mem_rdata;
                    end
                end
                ERR_RSP: begin
                    rsp_valid_r <= cur_onehot;
                    rsp_err_r   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int gl_idx[$];
    int gl_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding request tracked by timestamps.
    bit               rst_prev = 1'b0;
    bit               busy     = 1'b0;
    int               t_idx    = 0;
    bit               t_write  = 1'b0;
    bit               t_err    = 1'b0;
    logic [AW-1:0]    t_addr   = '0;
    logic [DW-1:0]    t_wdata  = '0;
    logic [DW-1:0]    rsp_data = '0;
    int               grant_cyc = 0;
    int               hs_cyc    = -1;
    int               rsp_due   = -1;
    int               ok_from   = 0;
    int               last      = N - 1;

    function automatic int rr_pick(input int from_last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(from_last + k) % N]) return (from_last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        bit           e_mem;
        bit           due_now;
        int           g;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) begin
                gl_idx.push_back(i);
                gl_cyc.push_back(cyc);
            end
        end
        if (rst) begin
            check("rst_req_ready", 64'(bus.req_ready), 64'(0));
            check("rst_mem_valid", 64'(bus.mem_valid), 64'(0));
            if (rst_prev) begin
                check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
                check("rst_rsp_err",   64'(bus.rsp_err),   64'(0));
                check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
                check("rst_mem_write", 64'(bus.mem_write), 64'(0));
                check("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
                check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
            end
            busy    = 1'b0;
            rsp_due = -1;
            hs_cyc  = -1;
            last    = N - 1;
            ok_from = cyc + 1;
        end else begin
            due_now = (rsp_due == cyc);
            e_rsp   = due_now ? (4'b0001 << t_idx) : 4'b0000;
            check("rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp));
            if (due_now) begin
                check("rsp_err", 64'(bus.rsp_err), 64'(t_err));
                if (t_err)         check("rsp_rdata_err", 64'(bus.rsp_rdata), 64'(0));
                else if (!t_write) check("rsp_rdata", 64'(bus.rsp_rdata), 64'(rsp_data));
            end
            e_mem = busy && !t_err && (hs_cyc < 0) && (cyc > grant_cyc);
            check("mem_valid", 64'(bus.mem_valid), 64'(e_mem));
            if (e_mem) begin
                check("mem_write", 64'(bus.mem_write), 64'(t_write));
                check("mem_addr",  64'(bus.mem_addr),  64'(t_addr));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(t_wdata));
            end
            g       = (!busy && cyc >= ok_from) ? rr_pick(last, bus.req_valid) : -1;
            e_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            check("req_ready", 64'(bus.req_ready), 64'(e_ready));

            if (due_now) begin
                busy    = 1'b0;
                rsp_due = -1;
                ok_from = cyc + 1;
            end
            if (e_mem && bus.mem_ready) begin
                hs_cyc = cyc;
                if (t_write) rsp_due = cyc + 1;
            end else if (busy && !t_err && !t_write && hs_cyc >= 0 && cyc > hs_cyc
                         && rsp_due < 0 && bus.mem_rsp_valid) begin
                rsp_due  = cyc + 1;
                rsp_data = bus.mem_rdata;
            end
            if (g >= 0) begin
                busy      = 1'b1;
                t_idx     = g;
                t_write   = bus.req_write[g];
                t_addr    = bus.req_addr[g*AW +: AW];
                t_wdata   = bus.req_wdata[g*DW +: DW];
                t_err     = (int'(t_addr) >= DEPTH);
                grant_cyc = cyc;
                hs_cyc    = -1;
                last      = g;
                if (t_err) rsp_due = cyc + 2;
            end
        end
        rst_prev = rst;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_write[i]          = wr;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic check_gl(input string name, input int k, input int exp_i, input int exp_c);
        if (gl_idx.size() > k) begin
            check({name, "_idx"}, 64'(gl_idx[k]), 64'(exp_i));
            check({name, "_cyc"}, 64'(gl_cyc[k]), 64'(exp_c));
        end else begin
            check({name, "_missing"}, 64'(gl_idx.size()), 64'(k + 1));
        end
    endtask

    task automatic clear_gl();
        gl_idx.delete();
        gl_cyc.delete();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int x;
        int exp_a[5] = '{0, 1, 2, 3, 0};
        bus.req_valid     = '0;
        bus.req_write     = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.mem_ready     = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        rst = 1'b1;
        step(3);

        // All four writing continuously: grants 0,1,2,3,0 every 3 cycles.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i));
        bus.mem_ready = 1'b1;
        bus.req_valid = 4'b1111;
        rst = 1'b0;
        clear_gl();
        x = cyc;
        step(14);
        bus.req_valid = '0;
        step(3);
        check("A_grant_count", 64'(gl_idx.size()), 64'(5));
        for (int i = 0; i < 5; i++) check_gl("A_grant", i, exp_a[i], x + 3*i);

        // Read from requester 2, memory returns data four cycles after grant.
        clear_gl();
        set_req(2, 1'b0, 16'h0010, 32'h0);
        bus.req_valid = 4'b0100;
        x = cyc;
        step(1);
        bus.req_valid = '0;
        step(3);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hDEAD_BEEF;
        step(1);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        check("B_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0100));
        check("B_rsp_rdata", 64'(bus.rsp_rdata), 64'(32'hDEAD_BEEF));
        check("B_rsp_err",   64'(bus.rsp_err),   64'(0));
        check_gl("B_grant", 0, 2, x);
        step(2);

        // Unmapped read from requester 1: error pulse two cycles after grant.
        clear_gl();
        set_req(1, 1'b0, 16'h1000, 32'h0);
        bus.req_valid = 4'b0010;
        x = cyc;
        step(1);
        bus.req_valid = '0;
        check("C_mem_valid", 64'(bus.mem_valid), 64'(0));
        step(1);
        check("C_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0010));
        check("C_rsp_err",   64'(bus.rsp_err),   64'(1));
        check("C_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        check_gl("C_grant", 0, 1, x);
        step(2);

        // Memory stalls for 5 cycles with other requesters pending.
        clear_gl();
        bus.mem_ready = 1'b0;
        set_req(0, 1'b1, 16'h0ABC, 32'h1234_5678);
        for (int i = 1; i < N; i++) set_req(i, 1'b1, 16'h0200 + 16'(i), 32'hB000_0000 + 32'(i));
        bus.req_valid = 4'b0001;
        step(1);
        bus.req_valid = 4'b1110;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("D_mem_valid", 64'(bus.mem_valid), 64'(1));
            check("D_mem_addr",  64'(bus.mem_addr),  64'(16'h0ABC));
            check("D_mem_wdata", 64'(bus.mem_wdata), 64'(32'h1234_5678));
            check("D_req_ready", 64'(bus.req_ready), 64'(0));
            step(1);
        end
        bus.mem_ready = 1'b1;
        bus.req_valid = '0;
        step(3);
        check("D_grant_count", 64'(gl_idx.size()), 64'(1));

        // Reset while waiting for read data; late return must be dropped.
        clear_gl();
        set_req(2, 1'b0, 16'h0020, 32'h0);
        bus.req_valid = 4'b0100;
        step(1);
        bus.req_valid = '0;
        step(1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0000_0055;
        step(1);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        check("E_no_rsp", 64'(bus.rsp_valid), 64'(0));
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'h0300 + 16'(i), 32'hC000_0000 + 32'(i));
        bus.req_valid = 4'b1111;
        #1;
        check("E_req_ready", 64'(bus.req_ready), 64'(4'b0001));
        step(1);
        bus.req_valid = '0;
        step(3);
        check("E_grant_count", 64'(gl_idx.size()), 64'(2));

        // Requesters 0 and 3 with last grant 0: 3 first, then 0.
        clear_gl();
        set_req(0, 1'b1, 16'h0400, 32'hD000_0000);
        set_req(3, 1'b1, 16'h0403, 32'hD000_0003);
        bus.req_valid = 4'b1001;
        x = cyc;
        step(4);
        bus.req_valid = '0;
        step(3);
        check_gl("F_grant", 0, 3, x);
        check_gl("F_grant", 1, 0, x + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
